// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : alu_pkg
//  Description: Shared encodings for the ALU control / multiply-divide block:
//               ALUOp values, funct and opcode constants, 4-bit operation
//               codes, FSM state type and the operation decoder.
//  Ports      : none (package)
//  Revision   : 1.0 - initial release
// ============================================================================
package alu_pkg;

   // ALUOp field driven by the main controller
   localparam logic [1:0] c_aluop_add   = 2'b00;
   localparam logic [1:0] c_aluop_sub   = 2'b01;
   localparam logic [1:0] c_aluop_rtype = 2'b10;
   localparam logic [1:0] c_aluop_imm   = 2'b11;

   // R-type funct values
   localparam logic [5:0] c_fn_sll   = 6'd0;
   localparam logic [5:0] c_fn_srl   = 6'd2;
   localparam logic [5:0] c_fn_mfhi  = 6'd16;
   localparam logic [5:0] c_fn_mflo  = 6'd18;
   localparam logic [5:0] c_fn_multu = 6'd25;
   localparam logic [5:0] c_fn_divu  = 6'd27;
   localparam logic [5:0] c_fn_add   = 6'd32;
   localparam logic [5:0] c_fn_sub   = 6'd34;
   localparam logic [5:0] c_fn_and   = 6'd36;
   localparam logic [5:0] c_fn_or    = 6'd37;
   localparam logic [5:0] c_fn_xor   = 6'd38;
   localparam logic [5:0] c_fn_nor   = 6'd39;
   localparam logic [5:0] c_fn_slt   = 6'd42;

   // Immediate-class opcodes
   localparam logic [5:0] c_opc_addi = 6'd8;
   localparam logic [5:0] c_opc_slti = 6'd10;
   localparam logic [5:0] c_opc_andi = 6'd12;
   localparam logic [5:0] c_opc_ori  = 6'd13;
   localparam logic [5:0] c_opc_xori = 6'd14;
   localparam logic [5:0] c_opc_lui  = 6'd15;

   // Operation codes presented on alu_ctrl
   localparam logic [3:0] c_op_and     = 4'd0;
   localparam logic [3:0] c_op_or      = 4'd1;
   localparam logic [3:0] c_op_add     = 4'd2;
   localparam logic [3:0] c_op_sll     = 4'd3;
   localparam logic [3:0] c_op_srl     = 4'd4;
   localparam logic [3:0] c_op_lui     = 4'd5;
   localparam logic [3:0] c_op_sub     = 4'd6;
   localparam logic [3:0] c_op_slt     = 4'd7;
   localparam logic [3:0] c_op_nor     = 4'd8;
   localparam logic [3:0] c_op_xor     = 4'd9;
   localparam logic [3:0] c_op_multu   = 4'd10;
   localparam logic [3:0] c_op_divu    = 4'd11;
   localparam logic [3:0] c_op_mfhi    = 4'd12;
   localparam logic [3:0] c_op_mflo    = 4'd13;
   localparam logic [3:0] c_op_illegal = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_EXEC = 3'd1,
      ST_MUL  = 3'd2,
      ST_DIV  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Pure combinational decode; every path falls back to ILLEGAL.
   function automatic logic [3:0] decode_op(input logic [1:0] alu_op,
                                            input logic [5:0] opcode,
                                            input logic [5:0] funct);
      logic [3:0] op;
      op = c_op_illegal;
      case (alu_op)
         c_aluop_add: op = c_op_add;
         c_aluop_sub: op = c_op_sub;
         c_aluop_rtype: begin
            case (funct)
               c_fn_and:   op = c_op_and;
               c_fn_or:    op = c_op_or;
               c_fn_add:   op = c_op_add;
               c_fn_sub:   op = c_op_sub;
               c_fn_slt:   op = c_op_slt;
               c_fn_nor:   op = c_op_nor;
               c_fn_xor:   op = c_op_xor;
               c_fn_sll:   op = c_op_sll;
               c_fn_srl:   op = c_op_srl;
               c_fn_multu: op = c_op_multu;
               c_fn_divu:  op = c_op_divu;
               c_fn_mfhi:  op = c_op_mfhi;
               c_fn_mflo:  op = c_op_mflo;
               default:    op = c_op_illegal;
            endcase
         end
         default: begin
            case (opcode)
               c_opc_lui:  op = c_op_lui;
               c_opc_addi: op = c_op_add;
               c_opc_andi: op = c_op_and;
               c_opc_ori:  op = c_op_or;
               c_opc_xori: op = c_op_xor;
               c_opc_slti: op = c_op_slt;
               default:    op = c_op_illegal;
            endcase
         end
      endcase
      return op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module     : alu_muldiv_iter
//  Description: Iterative unsigned multiply (shift-add) / divide (restoring)
//               datapath, one bit per cycle, W iterations per operation.
//  Ports      : clk, rst     - clock, async active-high reset
//               go           - load operands and begin (one cycle)
//               is_div       - 1 = divide a/b, 0 = multiply a*b
//               a, b         - operands (a = dividend / multiplicand)
//               out          - {hi,lo}: product, or {remainder,quotient}
//               last         - one-cycle flag: out holds the final answer
//  Revision   : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter #(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           go,
   input  logic           is_div,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] out,
   output logic           last
);

   localparam int CW = $clog2(W);

   logic [W-1:0]  r_hi;
   logic [W-1:0]  r_lo;
   logic [W-1:0]  r_opnd;
   logic [CW-1:0] r_cnt;
   logic          r_run;
   logic          r_is_div;

   logic [W:0]    w_sum;
   logic [W:0]    w_sh;
   logic [W:0]    w_diff;

   // Multiply: {hi,lo} starts as {0, multiplier}; add multiplicand into the
   // upper half when the low bit is set, then shift the pair right.
   // Divide:   {hi,lo} starts as {0, dividend}; shift left, trial-subtract
   // the divisor from the partial remainder, keep it only if non-negative.
   always_comb begin
      w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
      w_sh   = {r_hi, r_lo[W-1]};
      w_diff = w_sh - {1'b0, r_opnd};
   end

   assign out = {r_hi, r_lo};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi     <= '0;
         r_lo     <= '0;
         r_opnd   <= '0;
         r_cnt    <= '0;
         r_run    <= 1'b0;
         r_is_div <= 1'b0;
         last     <= 1'b0;
      end else begin
         last <= 1'b0;
         if (go) begin
            r_hi     <= '0;
            r_lo     <= is_div ? a : b;
            r_opnd   <= is_div ? b : a;
            r_cnt    <= '0;
            r_run    <= 1'b1;
            r_is_div <= is_div;
         end else if (r_run) begin
            if (r_is_div) begin
               if (!w_diff[W]) begin
                  r_hi <= w_diff[W-1:0];
                  r_lo <= {r_lo[W-2:0], 1'b1};
               end else begin
                  r_hi <= w_sh[W-1:0];
                  r_lo <= {r_lo[W-2:0], 1'b0};
               end
            end else begin
               r_hi <= w_sum[W:1];
               r_lo <= {w_sum[0], r_lo[W-1:1]};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(W-1)) begin
               r_run <= 1'b0;
               last  <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : alu_muldiv_ctrl
//  Description: ALU control + execute for the multi-cycle MIPS datapath with
//               iterative MULTU/DIVU, HI/LO registers and start/busy/done.
//  Ports      : clk, rst               - clock, async active-high reset
//               start                  - request, sampled in IDLE only
//               alu_op, opcode, funct  - decode inputs
//               a, b, shamt            - operands
//               alu_ctrl               - registered operation code
//               result, zero           - registered result and zero flag
//               hi, lo                 - HI/LO registers
//               busy, done             - handshake (done is a 1-cycle pulse)
//               illegal, div0          - status, registered with done
//  Revision   : 1.0 - initial release
// ============================================================================
module alu_muldiv_ctrl
   import alu_pkg::*;
#(
   parameter int W   = 32,
   parameter int SHW = $clog2(W)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [1:0]     alu_op,
   input  logic [5:0]     opcode,
   input  logic [5:0]     funct,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic [SHW-1:0] shamt,
   output logic [3:0]     alu_ctrl,
   output logic [W-1:0]   result,
   output logic           zero,
   output logic [W-1:0]   hi,
   output logic [W-1:0]   lo,
   output logic           busy,
   output logic           done,
   output logic           illegal,
   output logic           div0
);

   state_t         r_state;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [SHW-1:0] r_shamt;

   logic [3:0]     w_dec;
   logic           w_go;
   logic           w_is_div;
   logic [W-1:0]   w_res;
   logic [2*W-1:0] w_prod;
   logic           w_last;

   always_comb begin
      w_dec    = decode_op(alu_op, opcode, funct);
      w_is_div = (w_dec == c_op_divu);
      // The iterative unit is only launched when it will actually run;
      // a zero divisor is handled in a single EXEC cycle instead.
      w_go     = (r_state == ST_IDLE) && start &&
                 ((w_dec == c_op_multu) || (w_is_div && (b != '0)));
   end

   // Single-cycle ops evaluated on the latched operands during EXEC.
   // DIVU by zero and ILLEGAL fall through to a zero result.
   always_comb begin
      w_res = '0;
      case (alu_ctrl)
         c_op_and:  w_res = r_a & r_b;
         c_op_or:   w_res = r_a | r_b;
         c_op_add:  w_res = r_a + r_b;
         c_op_sll:  w_res = r_b << r_shamt;
         c_op_srl:  w_res = r_b >> r_shamt;
         c_op_lui:  w_res = r_b << (W/2);
         c_op_sub:  w_res = r_a - r_b;
         c_op_slt:  w_res = {{(W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
         c_op_nor:  w_res = ~(r_a | r_b);
         c_op_xor:  w_res = r_a ^ r_b;
         c_op_mfhi: w_res = hi;
         c_op_mflo: w_res = lo;
         default:   w_res = '0;
      endcase
   end

   alu_muldiv_iter #(.W(W)) u_iter (
      .clk    (clk),
      .rst    (rst),
      .go     (w_go),
      .is_div (w_is_div),
      .a      (a),
      .b      (b),
      .out    (w_prod),
      .last   (w_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_shamt  <= '0;
         alu_ctrl <= 4'd0;
         result   <= '0;
         zero     <= 1'b1;
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         illegal  <= 1'b0;
         div0     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  alu_ctrl <= w_dec;
                  r_a      <= a;
                  r_b      <= b;
                  r_shamt  <= shamt;
                  busy     <= 1'b1;
                  if (w_dec == c_op_multu)
                     r_state <= ST_MUL;
                  else if (w_is_div && (b != '0))
                     r_state <= ST_DIV;
                  else
                     r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               result  <= w_res;
               zero    <= (w_res == '0);
               illegal <= (alu_ctrl == c_op_illegal);
               // Only a zero-divisor DIVU ever reaches EXEC.
               div0    <= (alu_ctrl == c_op_divu);
               if (alu_ctrl == c_op_divu) begin
                  lo <= '1;
                  hi <= r_a;
               end
               busy    <= 1'b0;
               done    <= 1'b1;
               r_state <= ST_DONE;
            end
            ST_MUL, ST_DIV: begin
               if (w_last) begin
                  hi      <= w_prod[2*W-1:W];
                  lo      <= w_prod[W-1:0];
                  result  <= w_prod[W-1:0];
                  zero    <= (w_prod[W-1:0] == '0);
                  illegal <= 1'b0;
                  div0    <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : tb_alu_muldiv_ctrl
//  Description: Self-checking bench for alu_muldiv_ctrl (W=32 plus a W=8
//               instance) against an arithmetic reference model.
//  Ports      : none
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  alu_op;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] a, b;
   logic [4:0]  shamt;
   logic [3:0]  alu_ctrl;
   logic [31:0] result, hi, lo;
   logic        zero, busy, done, illegal, div0;

   logic        start8;
   logic [7:0]  a8, b8;
   logic [2:0]  shamt8;
   logic [3:0]  alu_ctrl8;
   logic [7:0]  result8, hi8, lo8;
   logic        zero8, busy8, done8, illegal8, div0_8;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   alu_muldiv_ctrl #(.W(32)) u_dut (
      .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .opcode(opcode),
      .funct(funct), .a(a), .b(b), .shamt(shamt), .alu_ctrl(alu_ctrl),
      .result(result), .zero(zero), .hi(hi), .lo(lo), .busy(busy),
      .done(done), .illegal(illegal), .div0(div0)
   );

   alu_muldiv_ctrl #(.W(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .alu_op(alu_op), .opcode(opcode),
      .funct(funct), .a(a8), .b(b8), .shamt(shamt8), .alu_ctrl(alu_ctrl8),
      .result(result8), .zero(zero8), .hi(hi8), .lo(lo8), .busy(busy8),
      .done(done8), .illegal(illegal8), .div0(div0_8)
   );

   task automatic check(input string tag, input string field,
                        input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
      end
   endtask

   // Decode table written straight from the instruction-set tables.
   function automatic logic [3:0] ref_decode(input logic [1:0] op,
                                             input logic [5:0] opc,
                                             input logic [5:0] fn);
      if (op == 2'd0) return 4'd2;
      if (op == 2'd1) return 4'd6;
      if (op == 2'd2) begin
         case (fn)
            6'd36: return 4'd0;   6'd37: return 4'd1;   6'd32: return 4'd2;
            6'd34: return 4'd6;   6'd42: return 4'd7;   6'd39: return 4'd8;
            6'd38: return 4'd9;   6'd0:  return 4'd3;   6'd2:  return 4'd4;
            6'd25: return 4'd10;  6'd27: return 4'd11;  6'd16: return 4'd12;
            6'd18: return 4'd13;  default: return 4'd15;
         endcase
      end
      case (opc)
         6'd15: return 4'd5;   6'd8:  return 4'd2;   6'd12: return 4'd0;
         6'd13: return 4'd1;   6'd14: return 4'd9;   6'd10: return 4'd7;
         default: return 4'd15;
      endcase
   endfunction

   // Issue one operation, wait (bounded) for done, compare with the model.
   // inject >= 0 pulses an extra start that many cycles after the request.
   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [5:0] opc, input logic [5:0] fn,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sh, input int inject);
      logic [3:0]  code;
      logic [31:0] e_res, nh, nl;
      logic [63:0] p;
      logic        e_ill, e_d0;
      int          lat, k, busy_cnt, got_k;
      logic        busy_at_done;

      code  = ref_decode(op, opc, fn);
      lat   = 2;
      e_res = 32'd0;
      e_ill = 1'b0;
      e_d0  = 1'b0;
      nh    = m_hi;
      nl    = m_lo;
      case (code)
         4'd0:  e_res = av & bv;
         4'd1:  e_res = av | bv;
         4'd2:  e_res = av + bv;
         4'd3:  e_res = bv << sh;
         4'd4:  e_res = bv >> sh;
         4'd5:  e_res = bv << 16;
         4'd6:  e_res = av - bv;
         4'd7:  e_res = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
         4'd8:  e_res = ~(av | bv);
         4'd9:  e_res = av ^ bv;
         4'd10: begin
            p = {32'd0, av} * {32'd0, bv};
            nh = p[63:32]; nl = p[31:0]; e_res = nl; lat = 34;
         end
         4'd11: begin
            if (bv != 32'd0) begin
               nl = av / bv; nh = av % bv; e_res = nl; lat = 34;
            end else begin
               nl = 32'hFFFF_FFFF; nh = av; e_d0 = 1'b1;
            end
         end
         4'd12: e_res = m_hi;
         4'd13: e_res = m_lo;
         default: e_ill = 1'b1;
      endcase

      @(negedge clk);
      alu_op = op; opcode = opc; funct = fn; a = av; b = bv; shamt = sh;
      start = 1'b1;
      k = 0; busy_cnt = 0; got_k = -1; busy_at_done = 1'b1;
      while (got_k < 0 && k < 200) begin
         @(posedge clk); #1;
         k++;
         if (done) begin
            got_k = k;
            busy_at_done = busy;
         end else if (busy) begin
            busy_cnt++;
         end
         @(negedge clk);
         start = (k == inject);
         if (k == inject) begin
            a = $urandom; b = $urandom_range(1, 9);
         end
      end
      check(tag, "latency", 32'(got_k), 32'(lat));
      check(tag, "busy_cycles", 32'(busy_cnt), 32'(lat - 1));
      check(tag, "busy_at_done", 32'(busy_at_done), 32'd0);
      check(tag, "alu_ctrl", 32'(alu_ctrl), 32'(code));
      check(tag, "result", result, e_res);
      check(tag, "zero", 32'(zero), 32'(e_res == 32'd0));
      check(tag, "illegal", 32'(illegal), 32'(e_ill));
      check(tag, "div0", 32'(div0), 32'(e_d0));
      check(tag, "hi", hi, nh);
      check(tag, "lo", lo, nl);
      m_hi = nh;
      m_lo = nl;
      @(negedge clk);
      start = 1'b0;
      check(tag, "done_pulse", 32'(done), 32'd0);
      check(tag, "idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [5:0] fn_list [14];
      logic [5:0] opc_list [7];
      int k8;

      fn_list  = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd39, 6'd38, 6'd0,
                   6'd2, 6'd25, 6'd27, 6'd16, 6'd18, 6'd63};
      opc_list = '{6'd15, 6'd8, 6'd12, 6'd13, 6'd14, 6'd10, 6'd9};

      rst = 1'b1; start = 1'b0; start8 = 1'b0;
      alu_op = 2'd0; opcode = 6'd0; funct = 6'd0;
      a = 32'd0; b = 32'd0; shamt = 5'd0;
      a8 = 8'd0; b8 = 8'd0; shamt8 = 3'd0;
      m_hi = 32'd0; m_lo = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset", "busy", 32'(busy), 32'd0);
      check("reset", "done", 32'(done), 32'd0);
      check("reset", "result", result, 32'd0);
      check("reset", "zero", 32'(zero), 32'd1);
      check("reset", "hi", hi, 32'd0);
      check("reset", "lo", lo, 32'd0);
      check("reset", "alu_ctrl", 32'(alu_ctrl), 32'd0);
      check("reset", "illegal", 32'(illegal), 32'd0);
      check("reset", "div0", 32'(div0), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed plan
      run_op("add_rtype", 2'd2, 6'd0, 6'd32, 32'd5, 32'd7, 5'd0, -1);
      run_op("lui", 2'd3, 6'd15, 6'd0, 32'd0, 32'h0000_ABCD, 5'd0, -1);
      run_op("imm_illegal", 2'd3, 6'd9, 6'd0, 32'd3, 32'd4, 5'd0, -1);
      run_op("multu", 2'd2, 6'd0, 6'd25, 32'hFFFF_FFFF, 32'd2, 5'd0, -1);
      run_op("mfhi", 2'd2, 6'd0, 6'd16, 32'd0, 32'd0, 5'd0, -1);
      run_op("mflo", 2'd2, 6'd0, 6'd18, 32'd0, 32'd0, 5'd0, -1);
      run_op("divu", 2'd2, 6'd0, 6'd27, 32'd100, 32'd7, 5'd0, -1);
      run_op("divu_zero", 2'd2, 6'd0, 6'd27, 32'd9, 32'd0, 5'd0, -1);
      run_op("multu_inject", 2'd2, 6'd0, 6'd25, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 5);
      run_op("done_start", 2'd0, 6'd0, 6'd0, 32'd1, 32'd1, 5'd0, 2);
      run_op("slt_neg", 2'd2, 6'd0, 6'd42, 32'hFFFF_FFFF, 32'd1, 5'd0, -1);
      run_op("sll31", 2'd2, 6'd0, 6'd0, 32'd0, 32'd1, 5'd31, -1);
      run_op("sub_wrap", 2'd1, 6'd0, 6'd0, 32'd0, 32'd1, 5'd0, -1);
      run_op("fn_illegal", 2'd2, 6'd0, 6'd1, 32'd7, 32'd7, 5'd0, -1);

      // Reset in the middle of a divide
      @(negedge clk);
      alu_op = 2'd2; funct = 6'd27; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_div", "busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_div_rst", "busy", 32'(busy), 32'd0);
      check("mid_div_rst", "hi", hi, 32'd0);
      check("mid_div_rst", "lo", lo, 32'd0);
      check("mid_div_rst", "zero", 32'(zero), 32'd1);
      m_hi = 32'd0; m_lo = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      run_op("add_after_rst", 2'd0, 6'd0, 6'd0, 32'd40, 32'd2, 5'd0, -1);

      // Randomised operations
      for (int i = 0; i < 30; i++) begin
         logic [1:0]  rop;
         logic [31:0] ra, rb;
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 1) == 1) rb = rb & 32'h0000_FFFF;
         run_op($sformatf("rand%0d", i), rop,
                opc_list[$urandom_range(0, 6)], fn_list[$urandom_range(0, 13)],
                ra, rb, 5'($urandom_range(0, 31)), -1);
      end

      // W=8 instance: MULTU 0xFF*0xFF, done W+2 cycles after the request
      @(negedge clk);
      alu_op = 2'd2; funct = 6'd25; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
      k8 = 0;
      while (k8 < 100) begin
         @(posedge clk); #1;
         k8++;
         if (done8) break;
         @(negedge clk);
         start8 = 1'b0;
      end
      check("w8_multu", "latency", 32'(k8), 32'd10);
      check("w8_multu", "hi", 32'(hi8), 32'h0000_00FE);
      check("w8_multu", "lo", 32'(lo8), 32'h0000_0001);
      check("w8_multu", "result", 32'(result8), 32'h0000_0001);
      @(negedge clk);
      start8 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
